// File: rtl/secded_pkg.sv
// SECDED (72,64) shared definitions: H matrix columns and syndrome helpers.
// Used by both the encoder and the decoder so the matrix exists exactly once.
package secded_pkg;

    localparam int DATA_W = 64;
    localparam int CHK_W  = 8;
    localparam int CW_W   = 72;

    // Distinct odd-weight (3 or 5) columns; never one-hot, never zero.
    localparam logic [CHK_W-1:0] H_COL [DATA_W] = '{
        8'h23, 8'h43, 8'h07, 8'h0B, 8'h0D, 8'h0E, 8'h13, 8'h15,
        8'h16, 8'h19, 8'h1A, 8'h1C, 8'h25, 8'h26, 8'h29, 8'h2A,
        8'h2C, 8'h31, 8'h32, 8'h34, 8'h38, 8'h45, 8'h46, 8'h49,
        8'h4A, 8'h4C, 8'h51, 8'h52, 8'h54, 8'h58, 8'h61, 8'h62,
        8'h64, 8'h68, 8'h70, 8'h83, 8'h85, 8'h86, 8'h89, 8'h8A,
        8'h8C, 8'h91, 8'h92, 8'h94, 8'h98, 8'hA1, 8'hA2, 8'hA4,
        8'hA8, 8'hB0, 8'hC1, 8'hC2, 8'hC4, 8'hC8, 8'hD0, 8'hE0,
        8'h1F, 8'h2F, 8'h37, 8'h3B, 8'h3D, 8'h3E, 8'h4F, 8'h57
    };

    function automatic logic [CHK_W-1:0] calc_syndrome(
        input logic [CW_W-1:0] cw
    );
        logic [CHK_W-1:0] s;
        s = cw[CW_W-1:DATA_W];
        for (int k = 0; k < DATA_W; k++) begin
            if (cw[k]) s = s ^ H_COL[k];
        end
        return s;
    endfunction

    function automatic logic [3:0] popcount8(
        input logic [CHK_W-1:0] v
    );
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < CHK_W; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic is_odd(input logic [CHK_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational 72->8 syndrome generator.
// Check bit j contributes a one-hot column, data bits use H_COL.
module secded_syndrome
    import secded_pkg::*;
(
    input  logic [CW_W-1:0]  cw,
    output logic [CHK_W-1:0] syn
);

    assign syn = calc_syndrome(cw);

endmodule

// File: rtl/secded_decoder.sv
// Two-stage (72,64) SECDED decoder with saturating SBE/DBE counters.
// Optional first-error log enabled by defining SECDED_ERR_LOG_EN.
module secded_decoder
    import secded_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              E_VALID,
    input  logic [CW_W-1:0]   E_DATA,
    output logic              D_VALID,
    output logic [DATA_W-1:0] D_DATA,
    output logic [CHK_W-1:0]  SYNDROME,
    output logic              SBE,
    output logic              DBE,
    input  logic              CNT_CLR,
    output logic [CNT_W-1:0]  SBE_CNT,
    output logic [CNT_W-1:0]  DBE_CNT
`ifdef SECDED_ERR_LOG_EN
    ,
    input  logic              LOG_CLR,
    output logic              LOG_VALID,
    output logic              LOG_DBE,
    output logic [CHK_W-1:0]  LOG_SYNDROME
`endif
);

    logic [CHK_W-1:0]  s0;
    logic              v1;
    logic [DATA_W-1:0] d1;
    logic [CHK_W-1:0]  s1;
    logic [DATA_W-1:0] fix;
    logic              hit;
    logic              onehot;
    logic              sbe_n;
    logic              dbe_n;

    secded_syndrome u_syn (
        .cw  (E_DATA),
        .syn (s0)
    );

    // Stage 1: capture data, syndrome and valid.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v1 <= 1'b0;
            d1 <= '0;
            s1 <= '0;
        end else begin
            v1 <= E_VALID;
            d1 <= E_DATA[DATA_W-1:0];
            s1 <= s0;
        end
    end

    // Classify the stage-1 syndrome and build the correction mask.
    always_comb begin
        fix = '0;
        hit = 1'b0;
        for (int k = 0; k < DATA_W; k++) begin
            if (H_COL[k] == s1) begin
                fix[k] = 1'b1;
                hit    = 1'b1;
            end
        end
        onehot = (popcount8(s1) == 4'd1);
        sbe_n  = is_odd(s1) && (hit || onehot);
        dbe_n  = (s1 != '0) && !sbe_n;
    end

    // Stage 2: corrected data and flags; data/syndrome hold when idle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            D_VALID  <= 1'b0;
            D_DATA   <= '0;
            SYNDROME <= '0;
            SBE      <= 1'b0;
            DBE      <= 1'b0;
        end else begin
            D_VALID <= v1;
            SBE     <= v1 && sbe_n;
            DBE     <= v1 && dbe_n;
            if (v1) begin
                D_DATA   <= d1 ^ fix;
                SYNDROME <= s1;
            end
        end
    end

    // Saturating error counters; clear beats a same-cycle increment.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            SBE_CNT <= '0;
            DBE_CNT <= '0;
        end else if (CNT_CLR) begin
            SBE_CNT <= '0;
            DBE_CNT <= '0;
        end else begin
            if (v1 && sbe_n && (SBE_CNT != '1))
                SBE_CNT <= SBE_CNT + 1'b1;
            if (v1 && dbe_n && (DBE_CNT != '1))
                DBE_CNT <= DBE_CNT + 1'b1;
        end
    end

`ifdef SECDED_ERR_LOG_EN
    // First-error log; held until cleared, clear beats a new error.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            LOG_VALID    <= 1'b0;
            LOG_DBE      <= 1'b0;
            LOG_SYNDROME <= '0;
        end else if (LOG_CLR) begin
            LOG_VALID    <= 1'b0;
            LOG_DBE      <= 1'b0;
            LOG_SYNDROME <= '0;
        end else if (!LOG_VALID && v1 && (sbe_n || dbe_n)) begin
            LOG_VALID    <= 1'b1;
            LOG_DBE      <= dbe_n;
            LOG_SYNDROME <= s1;
        end
    end
`endif

endmodule

// File: tb/tb_secded_decoder.sv
// Bench for secded_decoder: directed plan steps plus random stream,
// checked against a position-search SECDED reference model.
module tb_secded_decoder;
    import secded_pkg::*;

    typedef struct {
        bit          v;
        logic [63:0] d;
        logic [7:0]  s;
        bit          sbe;
        bit          dbe;
    } exp_t;

    logic        CLK;
    logic        RST_N;
    logic        E_VALID;
    logic [71:0] E_DATA;
    logic        CNT_CLR;
    logic        D_VALID, D_VALID2;
    logic [63:0] D_DATA, D_DATA2;
    logic [7:0]  SYNDROME, SYNDROME2;
    logic        SBE, SBE2, DBE, DBE2;
    logic [15:0] SBE_CNT, DBE_CNT;
    logic [1:0]  SBE_CNT2, DBE_CNT2;
`ifdef SECDED_ERR_LOG_EN
    logic        LOG_CLR;
    logic        LOG_VALID, LOG_VALID2, LOG_DBE, LOG_DBE2;
    logic [7:0]  LOG_SYNDROME, LOG_SYNDROME2;
`endif

    int n_cmp = 0;
    int n_err = 0;

    exp_t        prev;
    logic [63:0] hd_d;
    logic [7:0]  hd_s;
    int          m_sbe16, m_dbe16, m_sbe2, m_dbe2;

    secded_decoder #(.CNT_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .E_VALID(E_VALID), .E_DATA(E_DATA),
        .D_VALID(D_VALID), .D_DATA(D_DATA),
        .SYNDROME(SYNDROME), .SBE(SBE), .DBE(DBE),
        .CNT_CLR(CNT_CLR),
        .SBE_CNT(SBE_CNT), .DBE_CNT(DBE_CNT)
`ifdef SECDED_ERR_LOG_EN
        , .LOG_CLR(LOG_CLR), .LOG_VALID(LOG_VALID),
        .LOG_DBE(LOG_DBE), .LOG_SYNDROME(LOG_SYNDROME)
`endif
    );

    secded_decoder #(.CNT_W(2)) dut2 (
        .CLK(CLK), .RST_N(RST_N),
        .E_VALID(E_VALID), .E_DATA(E_DATA),
        .D_VALID(D_VALID2), .D_DATA(D_DATA2),
        .SYNDROME(SYNDROME2), .SBE(SBE2), .DBE(DBE2),
        .CNT_CLR(CNT_CLR),
        .SBE_CNT(SBE_CNT2), .DBE_CNT(DBE_CNT2)
`ifdef SECDED_ERR_LOG_EN
        , .LOG_CLR(LOG_CLR), .LOG_VALID(LOG_VALID2),
        .LOG_DBE(LOG_DBE2), .LOG_SYNDROME(LOG_SYNDROME2)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] col(input int j);
        logic [7:0] one;
        one = 8'd1;
        if (j < 64) return H_COL[j];
        return one << (j - 64);
    endfunction

    function automatic logic [71:0] enc(input logic [63:0] d);
        logic [7:0] c;
        c = '0;
        for (int k = 0; k < 64; k++)
            if (d[k]) c = c ^ H_COL[k];
        return {c, d};
    endfunction

    // Reference: syndrome as XOR of columns of set bits, then search
    // all 72 positions for the matching column.
    function automatic exp_t model(input logic [71:0] cw);
        exp_t e;
        int   pos;
        e.v = 1'b1;
        e.s = '0;
        for (int j = 0; j < 72; j++)
            if (cw[j]) e.s = e.s ^ col(j);
        e.sbe = 1'b0;
        e.dbe = 1'b0;
        pos = -1;
        if (e.s != 0) begin
            for (int j = 0; j < 72; j++)
                if (col(j) == e.s) pos = j;
            if (pos >= 0) begin
                cw[pos] = ~cw[pos];
                e.sbe = 1'b1;
            end else begin
                e.dbe = 1'b1;
            end
        end
        e.d = cw[63:0];
        return e;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        prev.v = 1'b0; prev.d = '0; prev.s = '0;
        prev.sbe = 1'b0; prev.dbe = 1'b0;
        hd_d = '0; hd_s = '0;
        m_sbe16 = 0; m_dbe16 = 0; m_sbe2 = 0; m_dbe2 = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cycle(input bit v, input logic [71:0] cw,
                         input bit clr);
        exp_t e;
        E_VALID = v;
        E_DATA  = cw;
        CNT_CLR = clr;
        tick();
        e = prev;
        if (clr) begin
            m_sbe16 = 0; m_dbe16 = 0; m_sbe2 = 0; m_dbe2 = 0;
        end else if (e.v) begin
            if (e.sbe) begin
                m_sbe16 = sat(m_sbe16, 65535);
                m_sbe2  = sat(m_sbe2, 3);
            end
            if (e.dbe) begin
                m_dbe16 = sat(m_dbe16, 65535);
                m_dbe2  = sat(m_dbe2, 3);
            end
        end
        if (e.v) begin
            hd_d = e.d;
            hd_s = e.s;
        end
        check("d_valid", 64'(D_VALID), 64'(e.v));
        check("sbe", 64'(SBE), 64'(e.v && e.sbe));
        check("dbe", 64'(DBE), 64'(e.v && e.dbe));
        check("d_data", D_DATA, hd_d);
        check("syndrome", 64'(SYNDROME), 64'(hd_s));
        check("sbe_cnt", 64'(SBE_CNT), 64'(m_sbe16));
        check("dbe_cnt", 64'(DBE_CNT), 64'(m_dbe16));
        check("sbe_cnt2", 64'(SBE_CNT2), 64'(m_sbe2));
        check("dbe_cnt2", 64'(DBE_CNT2), 64'(m_dbe2));
        if (v) prev = model(cw);
        else prev.v = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dv"}, 64'(D_VALID), 64'd0);
        check({tag, "_dd"}, D_DATA, 64'd0);
        check({tag, "_syn"}, 64'(SYNDROME), 64'd0);
        check({tag, "_sbe"}, 64'(SBE), 64'd0);
        check({tag, "_dbe"}, 64'(DBE), 64'd0);
        check({tag, "_sc"}, 64'(SBE_CNT), 64'd0);
        check({tag, "_dc"}, 64'(DBE_CNT), 64'd0);
    endtask

    initial begin
        logic [63:0] w;
        logic [71:0] cw;
        int          p;
`ifdef SECDED_ERR_LOG_EN
        LOG_CLR = 1'b0;
`endif
        RST_N   = 1'b0;
        E_VALID = 1'b0;
        E_DATA  = '0;
        CNT_CLR = 1'b0;
        model_reset();
        #1;
        check_zero("rst");
        #12 RST_N = 1'b1;

        w = 64'h0123_4567_89AB_CDEF;
        cycle(1'b1, enc(w), 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("clean_data", D_DATA, w);
        check("clean_syn", 64'(SYNDROME), 64'h00);

        cw = enc(w);
        cw[0] = ~cw[0];
        cycle(1'b1, cw, 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("b0_syn", 64'(SYNDROME), 64'h23);
        check("b0_data", D_DATA, w);
        check("b0_cnt", 64'(SBE_CNT), 64'd1);

        cw = enc(w);
        cw[64] = ~cw[64];
        cycle(1'b1, cw, 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("c1_syn", 64'(SYNDROME), 64'h01);
        check("c1_sbe", 64'(SBE), 64'd1);
        check("c1_data", D_DATA, w);

        cw = enc(w);
        cw[0] = ~cw[0];
        cw[1] = ~cw[1];
        cycle(1'b1, cw, 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("dbl_syn", 64'(SYNDROME), 64'h60);
        check("dbl_dbe", 64'(DBE), 64'd1);
        check("dbl_sbe", 64'(SBE), 64'd0);
        check("dbl_data", D_DATA, cw[63:0]);
        check("dbl_cnt", 64'(DBE_CNT), 64'd1);

        for (int i = 0; i < 6; i++) begin
            cw = enc({$urandom, $urandom});
            p  = int'($urandom_range(0, 71));
            cw[p] = ~cw[p];
            cycle(1'b1, cw, 1'b0);
        end
        check("sat_cnt2", 64'(SBE_CNT2), 64'd3);
        cycle(1'b0, '0, 1'b1);
        check("clr_sbe", 64'(SBE), 64'd1);
        check("clr_cnt2", 64'(SBE_CNT2), 64'd0);
        check("clr_cnt", 64'(SBE_CNT), 64'd0);

        for (int i = 0; i < 300; i++) begin
            int nf;
            cw = enc({$urandom, $urandom});
            nf = int'($urandom_range(0, 3));
            for (int f = 0; f < nf; f++) begin
                p = int'($urandom_range(0, 71));
                cw[p] = ~cw[p];
            end
            cycle(1'($urandom_range(0, 3) != 0), cw,
                  $urandom_range(0, 40) == 0);
            if (i == 150) begin
                E_VALID = 1'b1;
                E_DATA  = enc({$urandom, $urandom});
                #2 RST_N = 1'b0;
                #1;
                check_zero("mid_rst");
                model_reset();
                @(posedge CLK);
                #1;
                check("rst_hold_dv", 64'(D_VALID), 64'd0);
                #2 RST_N = 1'b1;
            end
        end

        for (int i = 0; i < 72; i++) begin
            cw = enc({$urandom, $urandom});
            cw[i] = ~cw[i];
            cycle(1'b1, cw, 1'b0);
        end
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
